// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the LED-strip serial link receiver and its bench.
//   state_t          : receiver FSM state (2-bit encoding; 2 and 3 unused)
//   BYTE_WIDTH       : bits per serial byte
//   BIT_CNT_WIDTH    : width of the per-byte bit counter
//   CLOCK_DELAY_TIME : transmitter half-period parameter, shared so the bench
//                      derives its bit timing from the transmitter's value
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int BYTE_WIDTH       = 8;
  localparam int BIT_CNT_WIDTH    = $clog2(BYTE_WIDTH);
  localparam int CLOCK_DELAY_TIME = 50;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_RECEIVE = 2'd1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-flop synchroniser for one asynchronous serial wire, plus one extra
// flop holding the previous synchronised value for edge detection.
//   clk     in  : receiver clock
//   rst_n   in  : asynchronous active-low reset, clears all flops
//   i_async in  : asynchronous input wire
//   o_sync  out : input after SYNC_STAGES flops
//   o_prev  out : o_sync delayed by one more cycle
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int SYNC_STAGES = 2   // legal range 2..3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_prev
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  // NOTE: flops are written with <= so every stage samples its neighbour's
  // pre-edge value; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_prev = r_prev;

endmodule

// File: rtl/spi_receiver.sv
// -----------------------------------------------------------------------------
// spi_receiver
// Receive side of the master-to-slave LED-strip serial link. Synchronises the
// serial data/clock wires into spi_clk, samples data MSB first on each rising
// serial-clock edge, and hands complete bytes to a single-entry valid/ready
// holding register. Stalled partial bytes are discarded after BIT_TIMEOUT
// cycles; bytes completing while the holding register is blocked are dropped.
//   spi_clk         in  : receiver clock
//   spi_reset_n     in  : asynchronous active-low reset
//   spi_input_data  in  : serial data (async)
//   spi_input_clock in  : serial clock (async, idle low)
//   spi_data_out    out : received byte, valid while spi_valid
//   spi_valid       out : holding register full
//   spi_ready       in  : consumer accepts when spi_valid & spi_ready
//   spi_busy        out : partial byte in progress (1..7 bits)
//   spi_overrun     out : one-cycle pulse, completed byte dropped
//   spi_frame_error out : one-cycle pulse, partial byte discarded on timeout
// -----------------------------------------------------------------------------
module spi_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int BIT_TIMEOUT   = 1000,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  spi_clk,
  input  logic                  spi_reset_n,
  input  logic                  spi_input_data,
  input  logic                  spi_input_clock,
  output logic [BYTE_WIDTH-1:0] spi_data_out,
  output logic                  spi_valid,
  input  logic                  spi_ready,
  output logic                  spi_busy,
  output logic                  spi_overrun,
  output logic                  spi_frame_error
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(BIT_TIMEOUT - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST     = BIT_CNT_WIDTH'(BYTE_WIDTH - 1);

  logic w_clk_sync;
  logic w_clk_prev;
  logic w_data_sync;
  logic w_unused_data_prev;
  logic w_rise;

  // Both wires share the same synchroniser depth so data and clock see
  // equal delay; data is taken at the stage where the clock edge is seen.
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clock (
    .clk     (spi_clk),
    .rst_n   (spi_reset_n),
    .i_async (spi_input_clock),
    .o_sync  (w_clk_sync),
    .o_prev  (w_clk_prev)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk     (spi_clk),
    .rst_n   (spi_reset_n),
    .i_async (spi_input_data),
    .o_sync  (w_data_sync),
    .o_prev  (w_unused_data_prev)
  );

  assign w_rise = w_clk_sync & ~w_clk_prev;

  // ---------------------------------------------------------------------------
  // Bit-assembly FSM
  // ---------------------------------------------------------------------------
  state_t                   r_state,     w_state_next;
  logic [BYTE_WIDTH-1:0]    r_shift,     w_shift_next;
  logic [BIT_CNT_WIDTH-1:0] r_bit_cnt,   w_bit_cnt_next;
  logic [TIMEOUT_WIDTH-1:0] r_timeout,   w_timeout_next;
  logic                     r_done,      w_done_next;
  logic                     r_frame_err, w_frame_err_next;

  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      r_state     <= STATE_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_timeout   <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_timeout   <= w_timeout_next;
      r_done      <= w_done_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_timeout_next   = r_timeout;
    w_done_next      = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      STATE_IDLE: begin
        // Gaps between bytes are unbounded: the timeout is held at zero here.
        w_bit_cnt_next = '0;
        w_timeout_next = '0;
        if (w_rise) begin
          w_shift_next   = {r_shift[BYTE_WIDTH-2:0], w_data_sync};
          w_bit_cnt_next = BIT_CNT_WIDTH'(1);
          w_state_next   = STATE_RECEIVE;
        end
      end

      STATE_RECEIVE: begin
        if (w_rise) begin
          w_shift_next   = {r_shift[BYTE_WIDTH-2:0], w_data_sync};
          w_timeout_next = '0;
          if (r_bit_cnt == BIT_LAST) begin
            // r_shift holds the full byte on the cycle r_done is high.
            w_done_next    = 1'b1;
            w_bit_cnt_next = '0;
            w_state_next   = STATE_IDLE;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_WIDTH'(1);
          end
        end else if (r_timeout == TIMEOUT_LAST) begin
          // This cycle's increment would reach BIT_TIMEOUT: abandon the byte.
          w_frame_err_next = 1'b1;
          w_shift_next     = '0;
          w_bit_cnt_next   = '0;
          w_timeout_next   = '0;
          w_state_next     = STATE_IDLE;
        end else begin
          w_timeout_next = r_timeout + TIMEOUT_WIDTH'(1);
        end
      end

      default: begin
        w_state_next   = STATE_IDLE;
        w_bit_cnt_next = '0;
        w_timeout_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-entry holding register
  // ---------------------------------------------------------------------------
  logic [BYTE_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;

  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        // An accept on the completion cycle frees the slot for the new byte.
        if (!r_valid || spi_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && spi_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign spi_data_out    = r_data;
  assign spi_valid       = r_valid;
  assign spi_busy        = (r_state == STATE_RECEIVE);
  assign spi_overrun     = r_overrun;
  assign spi_frame_error = r_frame_err;

endmodule

// File: tb/tb_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_receiver
// Self-checking bench for spi_receiver: a bit-banged transmitter model drives
// the serial wires, expected bytes go into a scoreboard queue, and a monitor
// pops and compares on every valid/ready handshake.
// -----------------------------------------------------------------------------
module tb_spi_receiver;
  import spi_pkg::*;

  localparam int SYNC_STAGES   = 2;
  localparam int BIT_TIMEOUT   = 1000;
  localparam int TIMEOUT_WIDTH = 16;
  localparam int HALF          = CLOCK_DELAY_TIME + 1;
  localparam int LATENCY       = SYNC_STAGES + 2;
  localparam int N_VECS        = 6;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       pin_data = 1'b0;
  logic       pin_clk  = 1'b0;
  logic       ready    = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  always #5 clk = ~clk;

  spi_receiver #(
    .SYNC_STAGES   (SYNC_STAGES),
    .BIT_TIMEOUT   (BIT_TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) dut (
    .spi_clk         (clk),
    .spi_reset_n     (rst_n),
    .spi_input_data  (pin_data),
    .spi_input_clock (pin_clk),
    .spi_data_out    (data_out),
    .spi_valid       (valid),
    .spi_ready       (ready),
    .spi_busy        (busy),
    .spi_overrun     (overrun),
    .spi_frame_error (frame_err)
  );

  int         n_checks     = 0;
  int         n_fail       = 0;
  int         cyc          = 0;
  int         last_rise    = 0;
  int         t_valid      = 0;
  int         valid_cycles = 0;
  int         n_ovr        = 0;
  int         n_ferr       = 0;
  logic       valid_d      = 1'b0;
  logic [7:0] exp_q[$];
  event       ev_last_rise;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[N_VECS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) valid_cycles++;
      if (valid && !valid_d) t_valid = cyc;
      valid_d = valid;
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
      if (valid && ready) begin
        check("byte expected at handshake", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("received byte", data_out, exp_q.pop_front());
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Transmitter model: data changes mid-low-phase, MSB first; busy is checked
  // at the end of each high phase (high for bits 1..7, low after the 8th).
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      pin_data = b[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      pin_clk   = 1'b1;
      last_rise = cyc;
      if (i == nbits - 1) -> ev_last_rise;
      repeat (HALF) @(posedge clk);
      #1;
      check("busy during byte", busy, (i < 7) ? 1 : 0);
      pin_clk = 1'b0;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, o0, f0, r0;

    vecs[0] = '{tx: 8'hA5, exp: 8'hA5};
    vecs[1] = '{tx: 8'h00, exp: 8'h00};
    vecs[2] = '{tx: 8'hFF, exp: 8'hFF};
    vecs[3] = '{tx: 8'h01, exp: 8'h01};
    vecs[4] = '{tx: 8'h80, exp: 8'h80};
    vecs[5] = '{tx: 8'h6D, exp: 8'h6D};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", data_out, 0);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    check("reset frame_error", frame_err, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) @(posedge clk);

    // Single and back-to-back bytes with ready held high
    for (int i = 0; i < N_VECS; i++) begin
      v0 = valid_cycles;
      o0 = n_ovr;
      exp_q.push_back(vecs[i].exp);
      send_bits(vecs[i].tx, 8);
      check("valid pulse width", valid_cycles - v0, 1);
      check("pin-to-valid latency", t_valid - last_rise, LATENCY);
      check("no overrun", n_ovr - o0, 0);
      check("data_out", data_out, vecs[i].exp);
    end
    check("scoreboard drained", exp_q.size(), 0);

    // Overrun: second byte dropped while first is held
    ready = 1'b0;
    o0 = n_ovr;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    repeat (10) @(posedge clk);
    #1;
    check("overrun pulses", n_ovr - o0, 1);
    check("overrun valid held", valid, 1);
    check("overrun data kept", data_out, 8'h3C);
    ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("overrun drained valid", valid, 0);
    check("overrun scoreboard", exp_q.size(), 0);

    // Timeout recovery
    f0 = n_ferr;
    send_bits(8'hA0, 3);
    r0 = last_rise + SYNC_STAGES + 1;
    wait_until(r0 + BIT_TIMEOUT - 1);
    check("frame_error before timeout", frame_err, 0);
    check("busy before timeout", busy, 1);
    wait_until(r0 + BIT_TIMEOUT);
    check("frame_error at timeout", frame_err, 1);
    check("busy at timeout", busy, 0);
    wait_until(r0 + BIT_TIMEOUT + 1);
    check("frame_error one cycle", frame_err, 0);
    check("frame_error pulses", n_ferr - f0, 1);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    repeat (10) @(posedge clk);
    #1;
    check("after timeout data", data_out, 8'h5A);

    // Asynchronous reset mid-byte
    send_bits(8'hF0, 4);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset data_out", data_out, 0);
    check("async reset valid", valid, 0);
    check("async reset overrun", overrun, 0);
    check("async reset frame_error", frame_err, 0);
    pin_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    repeat (10) @(posedge clk);
    #1;
    check("after reset data", data_out, 8'h81);

    // Completion with simultaneous accept
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8);
    #1;
    check("held first byte", data_out, 8'h11);
    o0 = n_ovr;
    exp_q.push_back(8'h22);
    fork
      send_bits(8'h22, 8);
      begin
        @(ev_last_rise);
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    #1;
    check("accept-on-complete valid", valid, 1);
    check("accept-on-complete data", data_out, 8'h22);
    check("accept-on-complete overrun", n_ovr - o0, 0);
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final valid", valid, 0);
    check("final scoreboard", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
